// File: rtl/i2s_mem_fetcher.sv
// i2s_mem_fetcher: serves I2S word requests from two host-filled ping-pong buffers over a single-word read port
module i2s_mem_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] buf0_base,
  input  logic [ADDR_WIDTH-1:0] buf1_base,
  input  logic [SIZE_WIDTH-1:0] buf_size,
  input  logic [1:0]            buf_ready_set,
  output logic [1:0]            buf_ready,
  output logic [1:0]            buf_done,
  output logic                  active_buf,
  output logic                  starved,
  input  logic                  request_data,
  input  logic [SIZE_WIDTH-1:0] request_size,
  output logic                  request_finished,
  output logic [31:0]           memory_data,
  output logic                  memory_data_strobe,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_ack,
  input  logic [31:0]           mem_rd_data
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SELECT   = 3'd1;
  localparam logic [2:0] WAIT_BUF = 3'd2;
  localparam logic [2:0] READ     = 3'd3;
  localparam logic [2:0] DELIVER  = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;
  localparam logic [2:0] HOLD     = 3'd6;
  logic [2:0]            state;
  logic [SIZE_WIDTH-1:0] remaining, offset, off_inc;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic                  drain, sel, wrap, zero_done;
  always_comb begin
    off_inc            = offset + SIZE_WIDTH'(1);
    sel                = buf_ready[active_buf] ? active_buf : ~active_buf;
    wrap               = enable && state == DELIVER && off_inc == buf_size;
    zero_done          = enable && state == SELECT && |buf_ready && buf_size == '0;
    buf_done           = wrap ? {active_buf, ~active_buf} : zero_done ? {sel, ~sel} : 2'b00;
    base_sel           = active_buf ? buf1_base : buf0_base;
    mem_rd_req         = state == READ || drain;
    mem_addr           = mem_rd_req ? base_sel + (ADDR_WIDTH'(offset) << 2) : '0;
    memory_data_strobe = enable && state == DELIVER;
    request_finished   = enable && state == FINISH;
    starved            = enable && state == WAIT_BUF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      offset      <= '0;
      active_buf  <= 1'b0;
      buf_ready   <= 2'b00;
      drain       <= 1'b0;
      memory_data <= '0;
    end else begin
      buf_ready <= (buf_ready & ~buf_done) | buf_ready_set;
      if (drain && mem_rd_ack) drain <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        if (state == READ && !mem_rd_ack) drain <= 1'b1;
      end else begin
        case (state)
          IDLE: if (request_data && !drain) begin
            remaining <= request_size;
            state     <= request_size == '0 ? FINISH : SELECT;
          end
          SELECT: if (zero_done) active_buf <= ~sel;
          else if (|buf_ready) begin
            state <= READ;
            if (sel != active_buf) begin
              active_buf <= sel;
              offset     <= '0;
            end
          end else state <= WAIT_BUF;
          WAIT_BUF: if (|buf_ready) state <= SELECT;
          READ: if (mem_rd_ack) begin
            memory_data <= mem_rd_data;
            state       <= DELIVER;
          end
          DELIVER: begin
            remaining <= remaining - SIZE_WIDTH'(1);
            offset    <= wrap ? '0 : off_inc;
            if (wrap) active_buf <= ~active_buf;
            state <= remaining == SIZE_WIDTH'(1) ? FINISH : SELECT;
          end
          FINISH: state <= HOLD;
          HOLD: if (!request_data) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2s_mem_fetcher.sv
// tb_i2s_mem_fetcher: directed checks of the ping-pong I2S memory fetcher
module tb_i2s_mem_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1, enable = 1'b0, request_data = 1'b0;
  logic [31:0] buf0_base = 32'h1000, buf1_base = 32'h2000;
  logic [23:0] buf_size = 24'd4, request_size = '0;
  logic [1:0]  buf_ready_set = 2'b00;
  logic [1:0]  buf_ready, buf_done;
  logic        active_buf, starved, request_finished, memory_data_strobe, mem_rd_req;
  logic [31:0] memory_data, mem_addr;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  int checks = 0, errors = 0;
  int lat = 2, wcnt = 0;
  int cyc = 0, n_fin = 0, n_req = 0, n_strobe = 0, done0 = 0, done1 = 0, last_strobe = 0, last_fin = 0, lat_err = 0;
  logic prev_ack = 1'b0;
  logic [31:0] rd_q[$], dat_q[$];
  i2s_mem_fetcher #(.ADDR_WIDTH(32), .SIZE_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buf0_base(buf0_base), .buf1_base(buf1_base),
    .buf_size(buf_size), .buf_ready_set(buf_ready_set), .buf_ready(buf_ready), .buf_done(buf_done),
    .active_buf(active_buf), .starved(starved), .request_data(request_data), .request_size(request_size),
    .request_finished(request_finished), .memory_data(memory_data), .memory_data_strobe(memory_data_strobe),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst || mem_rd_ack) begin
      mem_rd_ack <= 1'b0;
      wcnt       <= 0;
    end else if (mem_rd_req) begin
      if (wcnt >= lat) begin
        mem_rd_ack  <= 1'b1;
        mem_rd_data <= {16'hA5A5, mem_addr[15:0]};
      end else wcnt <= wcnt + 1;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (mem_rd_req && mem_rd_ack) rd_q.push_back(mem_addr);
    if (memory_data_strobe) begin
      dat_q.push_back(memory_data);
      n_strobe++;
      last_strobe = cyc;
      if (!prev_ack) lat_err++;
    end
    prev_ack = mem_rd_req && mem_rd_ack;
    if (request_finished) begin
      n_fin++;
      last_fin = cyc;
    end
    if (mem_rd_req) n_req++;
    if (buf_done[0]) done0++;
    if (buf_done[1]) done1++;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic mark_ready(input logic [1:0] b);
    buf_ready_set = b;
    tick();
    buf_ready_set = 2'b00;
  endtask
  task automatic wait_fin(input int f0);
    for (int i = 0; i < 300 && n_fin == f0; i++) @(negedge clk);
    checks++;
    if (n_fin == f0) begin
      errors++;
      $display("FAIL finish_timeout: got %0d finishes want %0d", n_fin - f0, 1);
    end
  endtask
  task automatic wait_req();
    for (int i = 0; i < 100 && !mem_rd_req; i++) @(negedge clk);
  endtask
  task automatic check_reads(input string nm, input int r0, input int d0, input logic [31:0] exp[$]);
    checks++;
    if (rd_q.size() - r0 != exp.size() || dat_q.size() - d0 != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d reads %0d strobes want %0d", nm, rd_q.size() - r0, dat_q.size() - d0, exp.size());
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++;
        if (rd_q[r0+k] !== exp[k] || dat_q[d0+k] !== {16'hA5A5, exp[k][15:0]}) begin
          errors++;
          $display("FAIL %s_word%0d: got addr %h data %h want addr %h data %h", nm, k, rd_q[r0+k], dat_q[d0+k], exp[k], {16'hA5A5, exp[k][15:0]});
        end
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    tick(2);
    checks++;
    if ({buf_ready, buf_done, active_buf, starved, request_finished, memory_data_strobe, mem_rd_req} !== 9'b0 || memory_data !== 0 || mem_addr !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got ready %b done %b act %b req %b addr %h data %h want all zero", buf_ready, buf_done, active_buf, mem_rd_req, mem_addr, memory_data);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_zero_size();
    int d0 = done0, q0 = n_req;
    buf_size = 24'd0;
    mark_ready(2'b01);
    request_size = 24'd1;
    request_data = 1'b1;
    tick(8);
    checks++;
    if (done0 - d0 != 1 || starved !== 1'b1 || n_req != q0 || buf_ready !== 2'b00 || active_buf !== 1'b1) begin
      errors++;
      $display("FAIL zero_size: got done0 %0d starved %b reqs %0d ready %b act %b want 1 1 0 00 1", done0 - d0, starved, n_req - q0, buf_ready, active_buf);
    end
    request_data = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    buf_size = 24'd4;
    tick();
  endtask
  task automatic test_basic();
    int r0 = rd_q.size(), d0 = dat_q.size(), f0 = n_fin;
    mark_ready(2'b01);
    checks++;
    if (buf_ready !== 2'b01) begin
      errors++;
      $display("FAIL ready_set: got %b want 01", buf_ready);
    end
    request_size = 24'd2;
    request_data = 1'b1;
    wait_fin(f0);
    request_data = 1'b0;
    tick(2);
    check_reads("basic", r0, d0, '{32'h1000, 32'h1004});
    checks++;
    if (last_fin != last_strobe + 1 || n_fin - f0 != 1 || lat_err != 0 || buf_ready !== 2'b01) begin
      errors++;
      $display("FAIL basic_timing: got fin_gap %0d fins %0d laterr %0d ready %b want 1 1 0 01", last_fin - last_strobe, n_fin - f0, lat_err, buf_ready);
    end
  endtask
  task automatic test_back_to_back();
    int r0 = rd_q.size(), d0 = dat_q.size(), f0 = n_fin, b0 = done0, b1 = done1;
    mark_ready(2'b10);
    request_size = 24'd4;
    request_data = 1'b1;
    wait_fin(f0);
    request_data = 1'b0;
    tick(2);
    check_reads("span", r0, d0, '{32'h1008, 32'h100C, 32'h2000, 32'h2004});
    checks++;
    if (done0 - b0 != 1 || done1 != b1 || active_buf !== 1'b1 || n_fin - f0 != 1 || buf_ready !== 2'b10 || lat_err != 0) begin
      errors++;
      $display("FAIL span_state: got done0 %0d done1 %0d act %b fins %0d ready %b want 1 0 1 1 10", done0 - b0, done1 - b1, active_buf, n_fin - f0, buf_ready);
    end
  endtask
  task automatic test_starved();
    int r0, d0, f0, q0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0 = rd_q.size();
    d0 = dat_q.size();
    f0 = n_fin;
    q0 = n_req;
    request_size = 24'd3;
    request_data = 1'b1;
    tick(6);
    checks++;
    if (starved !== 1'b1 || n_req != q0) begin
      errors++;
      $display("FAIL starved_wait: got starved %b reqs %0d want 1 0", starved, n_req - q0);
    end
    mark_ready(2'b10);
    wait_fin(f0);
    request_data = 1'b0;
    tick(2);
    check_reads("starved", r0, d0, '{32'h2000, 32'h2004, 32'h2008});
    checks++;
    if (starved !== 1'b0 || active_buf !== 1'b1) begin
      errors++;
      $display("FAIL starved_after: got starved %b act %b want 0 1", starved, active_buf);
    end
  endtask
  task automatic test_zero_request();
    int f0 = n_fin, q0 = n_req, s0 = n_strobe;
    request_size = 24'd0;
    request_data = 1'b1;
    tick(12);
    checks++;
    if (n_fin - f0 != 1 || n_req != q0 || n_strobe != s0) begin
      errors++;
      $display("FAIL zero_req: got fins %0d reqs %0d strobes %0d want 1 0 0", n_fin - f0, n_req - q0, n_strobe - s0);
    end
    request_data = 1'b0;
    tick(2);
    request_data = 1'b1;
    tick(4);
    request_data = 1'b0;
    tick(2);
    checks++;
    if (n_fin - f0 != 2) begin
      errors++;
      $display("FAIL zero_rerequest: got fins %0d want 2", n_fin - f0);
    end
  endtask
  task automatic test_abort();
    int r0 = rd_q.size(), s0 = n_strobe, f0 = n_fin, b1 = done1;
    lat = 10;
    request_size = 24'd2;
    request_data = 1'b1;
    wait_req();
    tick(2);
    enable = 1'b0;
    request_data = 1'b0;
    tick();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h200C) begin
      errors++;
      $display("FAIL abort_hold: got req %b addr %h want 1 0000200c", mem_rd_req, mem_addr);
    end
    tick(15);
    checks++;
    if (n_strobe != s0 || n_fin != f0 || mem_rd_req !== 1'b0 || rd_q.size() - r0 != 1) begin
      errors++;
      $display("FAIL abort_drain: got strobes %0d fins %0d req %b acks %0d want 0 0 0 1", n_strobe - s0, n_fin - f0, mem_rd_req, rd_q.size() - r0);
    end
    lat = 2;
    enable = 1'b1;
    request_size = 24'd1;
    request_data = 1'b1;
    wait_fin(f0);
    request_data = 1'b0;
    tick(2);
    checks++;
    if (rd_q[rd_q.size()-1] !== 32'h200C || done1 - b1 != 1 || buf_ready !== 2'b00 || n_strobe - s0 != 1) begin
      errors++;
      $display("FAIL abort_resume: got addr %h done1 %0d ready %b strobes %0d want 0000200c 1 00 1", rd_q[rd_q.size()-1], done1 - b1, buf_ready, n_strobe - s0);
    end
  endtask
  task automatic test_reset_mid_read();
    lat = 10;
    mark_ready(2'b01);
    request_size = 24'd2;
    request_data = 1'b1;
    wait_req();
    tick();
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL rst_pre: got req %b addr %h want 1 00001000", mem_rd_req, mem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({buf_ready, buf_done, active_buf, starved, request_finished, memory_data_strobe, mem_rd_req} !== 9'b0 || memory_data !== 0 || mem_addr !== 0) begin
      errors++;
      $display("FAIL rst_mid_read: got ready %b act %b req %b addr %h data %h want all zero", buf_ready, active_buf, mem_rd_req, mem_addr, memory_data);
    end
    rst = 1'b0;
    request_data = 1'b0;
    lat = 2;
    tick(2);
  endtask
  initial begin
    test_reset();
    test_zero_size();
    test_basic();
    test_back_to_back();
    test_starved();
    test_zero_request();
    test_abort();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
